// File: rtl/reg_shift_ctrl_pkg.sv
// Shared definitions for the register-sequencing serializer: FSM encodings,
// the register control bundle and counter width helper.
package reg_shift_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef struct packed {
    logic cl;
    logic ld;
    logic sr;
    logic sl;
  } reg_ctrl_t;

  // A divider by 1 still needs a one-bit counter to keep the port list legal.
  function automatic int div_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/reg_shift_ctrl_tick_gen.sv
// Bit-period divider: pulses tick on the last cycle of every DIV-cycle period
// while enabled; a synchronous clear restarts the period.
module tick_gen
  import reg_shift_ctrl_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = div_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_r;

  assign tick = en & (div_cnt_r == LAST);

  // Period counter, wraps DIV-1 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (clr) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (en) begin
      if (div_cnt_r == LAST) begin
        div_cnt_r <= {DW{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/reg_shift_ctrl.sv
// Sequences an external generic register to serialize a parallel word:
// load, one shift per bit period, clear, then a one-cycle done pulse.
module reg_shift_ctrl
  import reg_shift_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  msb_first,
  input  logic                  fill,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] reg_out,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic                  sdo,
  output logic                  sdo_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             dir_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             in_shift_s;
  logic             tick_s;
  reg_ctrl_t        ctrl_s;
  logic             unused_s;

  assign in_shift_s = (state_r == S_SHIFT);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~in_shift_s),
    .en    (in_shift_s),
    .tick  (tick_s)
  );

  // Next state and register controls; abort outranks the period decision
  always_comb begin
    state_nxt_s = state_r;
    ctrl_s      = '{cl: 1'b0, ld: 1'b0, sr: 1'b0, sl: 1'b0};
    case (state_r)
      S_IDLE: begin
        if (start) begin
          ctrl_s.ld   = 1'b1;
          state_nxt_s = S_SHIFT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          ctrl_s.cl   = 1'b1;
          state_nxt_s = S_IDLE;
        end else if (tick_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            ctrl_s.cl   = 1'b1;
            state_nxt_s = S_DONE;
          end else begin
            ctrl_s.sl = dir_r;
            ctrl_s.sr = ~dir_r;
          end
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM state, captured direction and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      dir_r     <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (ctrl_s.ld) begin
        dir_r     <= msb_first;
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (ctrl_s.sr || ctrl_s.sl) begin
        dir_r     <= dir_r;
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
        dir_r     <= dir_r;
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

  assign reg_in = din;
  assign reg_ir = fill;
  assign reg_il = fill;
  assign reg_cl = ctrl_s.cl;
  assign reg_ld = ctrl_s.ld;
  assign reg_sr = ctrl_s.sr;
  assign reg_sl = ctrl_s.sl;

  assign sdo       = in_shift_s & (dir_r ? reg_out[DATA_WIDTH-1] : reg_out[0]);
  assign sdo_valid = in_shift_s;
  assign busy      = in_shift_s | (state_r == S_DONE);
  assign done      = (state_r == S_DONE);

  // Only the end bits of the register are ever observed
  assign unused_s = ^reg_out;

endmodule

// File: tb/tb_reg_shift_ctrl.sv
// Directed bench for reg_shift_ctrl with a behavioural register attached;
// a second instance runs with DIV=1.
module tb_reg_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  logic        start, msb_first, fill, abort;
  logic [15:0] din, reg_out, reg_in;
  logic        reg_cl, reg_ld, reg_sr, reg_sl, reg_ir, reg_il;
  logic        sdo, sdo_valid, busy, done;

  logic        start_1, msb_first_1, fill_1, abort_1;
  logic [15:0] din_1, reg_out_1, reg_in_1;
  logic        reg_cl_1, reg_ld_1, reg_sr_1, reg_sl_1, reg_ir_1, reg_il_1;
  logic        sdo_1, sdo_valid_1, busy_1, done_1;

  always #5 clk = ~clk;

  reg_shift_ctrl #(.DATA_WIDTH(16), .DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msb_first(msb_first),
    .fill(fill), .abort(abort), .din(din), .reg_out(reg_out),
    .reg_in(reg_in), .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_sr(reg_sr),
    .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il), .sdo(sdo),
    .sdo_valid(sdo_valid), .busy(busy), .done(done)
  );

  reg_shift_ctrl #(.DATA_WIDTH(16), .DIV(1)) u_dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .msb_first(msb_first_1),
    .fill(fill_1), .abort(abort_1), .din(din_1), .reg_out(reg_out_1),
    .reg_in(reg_in_1), .reg_cl(reg_cl_1), .reg_ld(reg_ld_1), .reg_sr(reg_sr_1),
    .reg_sl(reg_sl_1), .reg_ir(reg_ir_1), .reg_il(reg_il_1), .sdo(sdo_1),
    .sdo_valid(sdo_valid_1), .busy(busy_1), .done(done_1)
  );

  // Generic register models (clear > load > shift right > shift left)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      reg_out <= 16'h0000;
    else if (reg_cl) reg_out <= 16'h0000;
    else if (reg_ld) reg_out <= reg_in;
    else if (reg_sr) reg_out <= {reg_ir, reg_out[15:1]};
    else if (reg_sl) reg_out <= {reg_out[14:0], reg_il};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        reg_out_1 <= 16'h0000;
    else if (reg_cl_1) reg_out_1 <= 16'h0000;
    else if (reg_ld_1) reg_out_1 <= reg_in_1;
    else if (reg_sr_1) reg_out_1 <= {reg_ir_1, reg_out_1[15:1]};
    else if (reg_sl_1) reg_out_1 <= {reg_out_1[14:0], reg_il_1};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transfer on the DIV=4 instance with per-cycle sdo checks
  task automatic xfer(input logic [15:0] d, input logic m);
    int sr_n, sl_n, cl_n, bad_n;
    logic exp_bit;
    sr_n = 0; sl_n = 0; cl_n = 0; bad_n = 0;
    din = d; msb_first = m; start = 1'b1;
    #1;
    chk("ld_on_accept", {31'd0, reg_ld}, 32'd1);
    chk("reg_in_eq_din", {16'd0, reg_in}, {16'd0, d});
    step();
    start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      exp_bit = m ? d[15-b] : d[b];
      for (int c = 0; c < 4; c++) begin
        chk("sdo_bit", {31'd0, sdo}, {31'd0, exp_bit});
        if (sdo_valid !== 1'b1 || busy !== 1'b1) bad_n++;
        sr_n += int'(reg_sr);
        sl_n += int'(reg_sl);
        cl_n += int'(reg_cl);
        step();
      end
    end
    chk("valid_busy_in_shift", bad_n, 32'd0);
    chk("done_at_65", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("valid_low_in_done", {31'd0, sdo_valid}, 32'd0);
    chk("reg_cleared", {16'd0, reg_out}, 32'd0);
    chk("sr_count", sr_n, m ? 32'd0 : 32'd15);
    chk("sl_count", sl_n, m ? 32'd15 : 32'd0);
    chk("cl_count", cl_n, 32'd1);
    step();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int ld_n, done_n, sr1_n;
    rst_n = 1'b0;
    start = 1'b0; msb_first = 1'b0; fill = 1'b0; abort = 1'b0; din = 16'h0000;
    start_1 = 1'b0; msb_first_1 = 1'b0; fill_1 = 1'b0; abort_1 = 1'b0; din_1 = 16'h0000;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sdo", {30'd0, sdo, sdo_valid}, 32'd0);
    chk("rst_ctrl", {28'd0, reg_cl, reg_ld, reg_sr, reg_sl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1 LSB-first, 2 MSB-first
    xfer(16'hA5C3, 1'b0);
    xfer(16'h8001, 1'b1);

    // 3 start held high throughout: single transfer, re-accept in first IDLE cycle
    din = 16'h3C5A; msb_first = 1'b0; start = 1'b1;
    step();
    ld_n = 0;
    for (int i = 0; i < 64; i++) begin
      ld_n += int'(reg_ld);
      step();
    end
    chk("held_start_done", {31'd0, done}, 32'd1);
    chk("held_start_no_ld_in_done", {31'd0, reg_ld}, 32'd0);
    chk("held_start_no_reload", ld_n, 32'd0);
    step();
    chk("reaccept_idle", {31'd0, busy}, 32'd0);
    chk("reaccept_ld", {31'd0, reg_ld}, 32'd1);
    step();
    start = 1'b0;
    chk("reaccept_busy", {31'd0, busy}, 32'd1);

    // 4 abort in first cycle of third bit period
    repeat (8) step();
    abort = 1'b1;
    #1;
    chk("abort_cl", {31'd0, reg_cl}, 32'd1);
    chk("abort_no_shift", {30'd0, reg_sr, reg_sl}, 32'd0);
    step();
    abort = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_no_valid", {31'd0, sdo_valid}, 32'd0);
    chk("abort_reg_zero", {16'd0, reg_out}, 32'd0);
    done_n = 0;
    for (int i = 0; i < 70; i++) begin
      done_n += int'(done);
      step();
    end
    chk("abort_no_done", done_n, 32'd0);
    abort = 1'b1;
    #1;
    chk("abort_idle_no_cl", {31'd0, reg_cl}, 32'd0);
    step();
    abort = 1'b0;
    chk("abort_idle_stays", {31'd0, busy}, 32'd0);

    // 5 reset mid-SHIFT
    din = 16'hF0F0; msb_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("mid_rst_sdo", {30'd0, sdo, sdo_valid}, 32'd0);
    chk("mid_rst_ctrl", {28'd0, reg_cl, reg_ld, reg_sr, reg_sl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {31'd0, done}, 32'd0);
    xfer(16'h1234, 1'b0);

    // 6 DIV=1, all ones with fill=1
    din_1 = 16'hFFFF; fill_1 = 1'b1; start_1 = 1'b1;
    step();
    start_1 = 1'b0;
    sr1_n = 0;
    for (int i = 0; i < 16; i++) begin
      chk("div1_sdo", {30'd0, sdo_1, sdo_valid_1}, 32'd3);
      chk("div1_no_done", {31'd0, done_1}, 32'd0);
      sr1_n += int'(reg_sr_1);
      step();
    end
    chk("div1_done_at_17", {31'd0, done_1}, 32'd1);
    chk("div1_sr_count", sr1_n, 32'd15);
    chk("div1_reg_cleared", {16'd0, reg_out_1}, 32'd0);
    step();
    chk("div1_idle", {30'd0, busy_1, done_1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
